// File: rtl/peak_locator_if.sv
// rtl/peak_locator_if.sv - score stream in, peak detection out, for peak_locator
// The master drives cell scores and observes detections; the slave is the locator.
interface peak_locator_if #(
  parameter int SCORE_WIDTH = 8
);
  logic                   valid_in;
  logic [4:0]             hcount_in;
  logic [4:0]             vcount_in;
  logic [SCORE_WIDTH-1:0] score_in;
  logic                   data_valid_out;
  logic [4:0]             hcount_out;
  logic [4:0]             vcount_out;
  logic [SCORE_WIDTH-1:0] score_out;
  logic                   frame_err_out;

  modport master (
    output valid_in, hcount_in, vcount_in, score_in,
    input  data_valid_out, hcount_out, vcount_out, score_out, frame_err_out
  );

  modport slave (
    input  valid_in, hcount_in, vcount_in, score_in,
    output data_valid_out, hcount_out, vcount_out, score_out, frame_err_out
  );
endinterface

// File: rtl/peak_locator.sv
// rtl/peak_locator.sv - finds the highest-scoring cell of a raster frame
// Emits its (optionally clamped) coordinates one cycle after the last pixel.
module peak_locator #(
  parameter int SCORE_WIDTH = 8,
  parameter int GRID_DIM    = 32,
  parameter int THRESHOLD   = 64,
  parameter bit CLAMP_EN    = 1'b1
) (
  input logic           clk_in,
  input logic           rst_in,
  peak_locator_if.slave bus
);

  localparam logic [4:0] LAST = 5'(GRID_DIM - 1);
  localparam logic [4:0] LO   = 5'd3;
  localparam logic [4:0] HI   = 5'(GRID_DIM - 4);
  localparam logic [SCORE_WIDTH-1:0] THR = SCORE_WIDTH'(THRESHOLD);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

  state_t                 state, state_next;
  logic [4:0]             exp_h, exp_v;
  logic [4:0]             max_h, max_v;
  logic [SCORE_WIDTH-1:0] max_score;
  logic                   start, take, err;
  logic                   at_expected, is_origin, is_last;

  assign at_expected = (bus.hcount_in == exp_h) && (bus.vcount_in == exp_v);
  assign is_origin   = (bus.hcount_in == 5'd0) && (bus.vcount_in == 5'd0);
  assign is_last     = (exp_h == LAST) && (exp_v == LAST);

  function automatic logic [4:0] clamp(input logic [4:0] c);
    if (!CLAMP_EN) return c;
    if (c < LO)    return LO;
    if (c > HI)    return HI;
    return c;
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  // EMIT behaves like IDLE for inputs so back-to-back frames need no gap.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    take       = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE, EMIT: begin
        state_next = IDLE;
        if (bus.valid_in && is_origin) begin
          start      = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (bus.valid_in) begin
          if (at_expected) begin
            take = 1'b1;
            if (is_last) state_next = EMIT;
          end else begin
            err = 1'b1;
            if (is_origin) start = 1'b1;
            else           state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      exp_h              <= 5'd0;
      exp_v              <= 5'd0;
      max_h              <= 5'd0;
      max_v              <= 5'd0;
      max_score          <= '0;
      bus.data_valid_out <= 1'b0;
      bus.frame_err_out  <= 1'b0;
      bus.hcount_out     <= 5'd0;
      bus.vcount_out     <= 5'd0;
      bus.score_out      <= '0;
    end else begin
      bus.data_valid_out <= 1'b0;
      bus.frame_err_out  <= err;
      if (start) begin
        max_score <= bus.score_in;
        max_h     <= 5'd0;
        max_v     <= 5'd0;
        exp_h     <= 5'd1;
        exp_v     <= 5'd0;
      end else if (take) begin
        // Strictly greater, so ties keep the earlier raster position.
        if (bus.score_in > max_score) begin
          max_score <= bus.score_in;
          max_h     <= exp_h;
          max_v     <= exp_v;
        end
        if (exp_h == LAST) begin
          exp_h <= 5'd0;
          exp_v <= exp_v + 5'd1;
        end else begin
          exp_h <= exp_h + 5'd1;
        end
      end
      if (state == EMIT && max_score >= THR) begin
        bus.data_valid_out <= 1'b1;
        bus.hcount_out     <= clamp(max_h);
        bus.vcount_out     <= clamp(max_v);
        bus.score_out      <= max_score;
      end
    end
  end

endmodule

// File: doc/peak_locator.md
Name: peak_locator

Overview:
Upstream stage of draw_box. Consumes one raster-ordered frame of per-cell detection scores on the GRID_DIM x GRID_DIM grid and finds the highest-scoring cell. At end of frame it emits that cell's coordinates as a single-cycle data_valid_out pulse, which drives draw_box's data_valid_in, hcount_pred and vcount_pred. Malformed frames are discarded and flagged.

Parameters:
SCORE_WIDTH, 8, width of score_in and score_out.
GRID_DIM, 32, cells per row and per column; legal range 8..32.
THRESHOLD, 64, minimum peak score for a valid detection; compared unsigned, and the peak must be >= THRESHOLD.
CLAMP_EN, 1, when 1, clamp emitted coordinates into [3, GRID_DIM-4] so the 7x7 box outline never wraps.

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
valid_in  input  1  score_in, hcount_in and vcount_in are valid this cycle
hcount_in  input  5  column of the incoming cell
vcount_in  input  5  row of the incoming cell
score_in  input  SCORE_WIDTH  unsigned score of the incoming cell
data_valid_out  output  1  one-cycle pulse: detection available; feeds draw_box data_valid_in
hcount_out  output  5  peak column, possibly clamped
vcount_out  output  5  peak row, possibly clamped
score_out  output  SCORE_WIDTH  peak score; held until the next emit
frame_err_out  output  1  one-cycle pulse: frame discarded

Behaviour:
- Reset (rst_in high at a clock edge): state=IDLE. data_valid_out=0, frame_err_out=0, hcount_out=0, vcount_out=0, score_out=0. Expected counters and running max are cleared. Reset mid-frame abandons the frame with no pulse of any kind.
- States:
  - IDLE: ignore all inputs until valid_in arrives with (h,v)=(0,0). That pixel is accepted as the first of the frame; go to SCAN.
  - SCAN: each valid_in beat must match the expected raster position (h increments; at GRID_DIM-1 it wraps to 0 and v increments). Cycles with valid_in=0 are stalls and leave all state unchanged.
  - EMIT: lasts exactly one cycle; return to IDLE.
- Max tracking:
  - The first pixel of a frame loads the running max unconditionally.
  - Later pixels replace the max only when score_in is strictly greater. Ties keep the earlier raster position.
- End of frame: occurs when pixel (GRID_DIM-1, GRID_DIM-1) is accepted, and that pixel takes part in the comparison. The next cycle is EMIT:
  - data_valid_out=1 only if the final max >= THRESHOLD.
  - When the pulse fires, hcount_out, vcount_out and score_out update in the same cycle and then hold.
  - Below threshold: no pulse, and outputs keep their previous values.
- Latency: last pixel accepted at edge N means data_valid_out is high after edge N+1. The pulse is never longer than one cycle, because draw_box restarts its sequence on every cycle data_valid_in is high.
- Clamp: when CLAMP_EN=1, each coordinate c is output as max(3, min(c, GRID_DIM-4)). When CLAMP_EN=0, the raw coordinate is output. score_out is never altered.
- Errors (in SCAN):
  - A beat whose coordinates are not the expected position: frame_err_out pulses on the next cycle and state becomes IDLE.
  - Exception: if that bad beat is (0,0), the frame is still flagged, but the (0,0) pixel is accepted as the start of a new frame and state stays SCAN.
  - Coordinates >= GRID_DIM count as mismatches.
- Simultaneous events: valid_in arriving in the EMIT cycle is treated as arriving in IDLE, so a (0,0) beat immediately following the last pixel starts the next frame with no gap. rst_in has priority over everything.
- Throughput: one pixel per clock, no backpressure, and no ready signal.

Test Plan:
- Reset, then a full 32x32 frame with all scores 0 except (10,20)=200 -> one data_valid_out pulse 1 cycle after (31,31) is accepted; hcount_out=10, vcount_out=20, score_out=200; frame_err_out stays 0.
- Tie and threshold: (5,5)=100 and (6,5)=100 -> emits (5,5). Next frame with every score 63 -> no pulse, and outputs still hold (5,5)/100.
- Clamp: peak at (0,31)=255 with CLAMP_EN=1 -> hcount_out=3, vcount_out=28. Same frame with CLAMP_EN=0 -> hcount_out=0, vcount_out=31. Peak at (31,31) with CLAMP_EN=1 -> 28,28.
- Stalls: the same frame as test 1 with random valid_in=0 gaps (about 30%) -> identical result, pulse 1 cycle after the last pixel.
- Errors:
  - Skip pixel (4,2) -> frame_err_out pulse 1 cycle later; no data_valid_out for that frame.
  - (0,0) injected at position (7,3) -> error pulse, and the following complete frame from that (0,0) emits correctly.
- rst_in asserted at pixel (15,15) with a 250 peak already seen, then a full frame peaking at (2,9)=90 -> no pulse from the aborted frame; emits (3,9)/90 with clamping on.
